// File: rtl/regfile_snap.sv
// Register file with two async read ports, one write port and a snapshot/stream debug port.
// Optional write-to-read forwarding is enabled with the REGFILE_FWD_EN macro.

module regfile_snap_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cap_en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] sq
);
  // Shadow samples q before the same-edge write lands, giving a pre-write snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      sq <= '0;
    end else begin
      if (cap_en) sq <= q;
      if (wr_en)  q  <= wdata;
    end
  end
endmodule

module regfile_snap #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             snap_req,
  output logic             snap_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last
);
  typedef enum logic {IDLE, DUMP} state_t;

  state_t                        state;
  logic [DEPTH-1:0][WIDTH-1:0]   regs;
  logic [DEPTH-1:0][WIDTH-1:0]   shadow;
  logic                          cap;

  assign cap = (state == IDLE) && snap_req;

  // Out-of-range write addresses match no cell and are dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    regfile_snap_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (we && (waddr == AW'(i))),
      .wdata  (wdata),
      .cap_en (cap),
      .q      (regs[i]),
      .sq     (shadow[i])
    );
  end

  always_comb begin
    rdata_a = '0;
    if (int'(raddr_a) < DEPTH) rdata_a = regs[raddr_a];
`ifdef REGFILE_FWD_EN
    if (we && (waddr == raddr_a) && (int'(raddr_a) < DEPTH)) rdata_a = wdata;
`endif
  end

  always_comb begin
    rdata_b = '0;
    if (int'(raddr_b) < DEPTH) rdata_b = regs[raddr_b];
`ifdef REGFILE_FWD_EN
    if (we && (waddr == raddr_b) && (int'(raddr_b) < DEPTH)) rdata_b = wdata;
`endif
  end

  always_comb begin
    dump_data = '0;
    if (dump_valid) dump_data = shadow[dump_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      snap_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            state      <= DUMP;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            dump_last  <= 1'b0;
            snap_busy  <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= IDLE;
              dump_idx   <= '0;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              snap_busy  <= 1'b0;
            end else begin
              dump_idx  <= dump_idx + 1'b1;
              // Next beat is last when the current one is DEPTH-2.
              dump_last <= (dump_idx == AW'(DEPTH-2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/regfile_snap.md
# regfile_snap

Parametrised general-purpose register file for the custom processor: one write port, two asynchronous read ports, and a snapshot-and-stream debug port. The debug port takes an atomic copy of every register and streams it out with a valid/ready handshake, so the register state can be dumped in hardware instead of probed hierarchically. It sits between the decoder/ALU writeback path and the operand fetch path inside `top`.

## Interface
- `WIDTH`, 16, register data width in bits (≥1)
- `DEPTH`, 4, number of registers (≥2)
- `AW`, `$clog2(DEPTH)`, address width (derived, do not override)

- `clk`  input  1  sole clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `we`  input  1  write enable
- `waddr`  input  AW  write address
- `wdata`  input  WIDTH  write data
- `raddr_a`  input  AW  read port A address
- `rdata_a`  output  WIDTH  read port A data (combinational)
- `raddr_b`  input  AW  read port B address
- `rdata_b`  output  WIDTH  read port B data (combinational)
- `snap_req`  input  1  request a snapshot and dump
- `snap_busy`  output  1  dump in progress
- `dump_valid`  output  1  `dump_data` and `dump_idx` are valid
- `dump_ready`  input  1  consumer accepts the current beat
- `dump_idx`  output  AW  register index of the current beat
- `dump_data`  output  WIDTH  snapshot value of register `dump_idx`
- `dump_last`  output  1  current beat is index `DEPTH-1`

## Operation
- Storage: `DEPTH` × `WIDTH` registers plus a `DEPTH` × `WIDTH` shadow array.
- Write: on a rising edge with `we`=1 and `waddr` < `DEPTH`, `reg[waddr]` ← `wdata`. Writes with `waddr` ≥ `DEPTH` (non-power-of-two `DEPTH`) are dropped.
- Read: `rdata_x` = `reg[raddr_x]`, or 0 if `raddr_x` ≥ `DEPTH`. Both ports may address the same register.
- FSM states: IDLE, DUMP.
  - IDLE: if `snap_req`=1 at a rising edge, shadow ← all registers (the values *before* any write on that same edge). `dump_idx` ← 0. Go to DUMP.
  - DUMP: `dump_valid`=1. `dump_data`=`shadow[dump_idx]`. `dump_last`=(`dump_idx`==`DEPTH-1`).
  - A beat transfers on a rising edge with `dump_valid`&&`dump_ready`. On a transfer, `dump_idx` increments. If the beat was last, the FSM returns to IDLE.
- `snap_busy` = (state==DUMP).
- `snap_req` is ignored in DUMP. A new snapshot needs `snap_req` while in IDLE, no earlier than the edge after the last transfer.
- Register writes continue normally during DUMP and do not alter the shadow.
- `dump_data` and `dump_idx` are 0 while `dump_valid`=0.

## Timing
- Reset (asynchronous, immediate): all registers and shadow cleared to 0; state=IDLE; `dump_idx`=0.
- Output values while in reset: `snap_busy`=0, `dump_valid`=0, `dump_last`=0, `dump_data`=0, `rdata_a`/`rdata_b`=0.
- Write-to-read latency: 1 cycle; the new value is visible on read ports after the write edge.
- Snapshot latency: `snap_req` sampled at edge k → `dump_valid`=1 after edge k.
- Dump length: exactly `DEPTH` beats. With `dump_ready` held at 1, the last beat is in cycle k+`DEPTH` and `dump_valid` falls after edge k+`DEPTH`.
- Backpressure: while `dump_valid`=1 and `dump_ready`=0, `dump_idx`, `dump_data` and `dump_last` hold stable. `dump_valid` never deasserts before its beat transfers.
- `dump_ready` asserted in IDLE has no effect.
- Reset mid-dump aborts the stream immediately. No partial beat completes.

## Configuration
- Macro `REGFILE_FWD_EN` (write-to-read forwarding):
  - Defined: when `we`=1 and `waddr`==`raddr_x` (valid address), `rdata_x`=`wdata` combinationally, in the same cycle.
  - Undefined: read ports show only the stored value; a same-cycle write becomes visible the next cycle.
- The snapshot path is identical in both builds. It always captures pre-write values.

## Test plan
- Reset/write/read: assert `rst_n`=0 for 1 ns → all reads 0, `dump_valid`=0. Write reg1=0x00AA, reg3=0xBEEF → next cycle `rdata_a`(1)=0x00AA, `rdata_b`(3)=0xBEEF.
- Forwarding: `we`=1, `waddr`=2, `wdata`=0x1234, `raddr_a`=2 in the same cycle.
  - With `REGFILE_FWD_EN`: `rdata_a`=0x1234 that cycle.
  - Without: `rdata_a`=old value (0), and 0x1234 the next cycle.
- Full-speed dump: regs = {0x0011, 0x0022, 0x0033, 0x0044}, `dump_ready`=1, one-cycle `snap_req` → 4 consecutive beats, idx 0..3, data 0x0011..0x0044, `dump_last` only on idx 3, `snap_busy` low after the 4th edge.
- Backpressure and atomicity:
  - `snap_req` at the same edge as writing reg0=0xFFFF → beat 0 carries the old reg0.
  - `dump_ready` toggled 1,0,0,1,… → each beat holds stable while stalled; exactly 4 transfers.
  - Writes during the dump do not change the dumped data.
- Ignored request / abort:
  - `snap_req` pulsed during DUMP → no restart; still exactly 4 beats.
  - `rst_n`=0 at beat 2 → `dump_valid`=0 immediately, registers 0; the next `snap_req` dumps all zeros starting at idx 0.
- Parametrisation: `WIDTH`=32, `DEPTH`=6 → 6 beats, last at idx 5. Write to address 7 is dropped. Read of address 6 returns 0.
